// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between the icache and dcache.
// Grants whole line transactions, round-robin on ties, with the winner's command latched until pmem_resp.
module cache_arbiter #(
  parameter int s_addr = 32,
  parameter int s_line = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_addr-1:0] i_address,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [s_line-1:0] i_wdata,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic [s_addr-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic [s_addr-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // state  | meaning
  // IDLE   | no transaction in flight
  // BUSY_I | icache transaction in flight
  // BUSY_D | dcache transaction in flight
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state, state_next;
  logic   last_d;
  logic   i_pend, d_pend;
  logic   grant_i, grant_d;

  assign i_pend = i_read | i_write;
  assign d_pend = d_read | d_write;

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend && d_pend) begin
          grant_i = last_d;
          grant_d = ~last_d;
        end else begin
          grant_i = i_pend;
          grant_d = d_pend;
        end
        if (grant_i) state_next = BUSY_I;
        else if (grant_d) state_next = BUSY_D;
      end
      BUSY_I: begin
        if (pmem_resp) begin
          i_resp     = 1'b1;
          state_next = IDLE;
        end
      end
      BUSY_D: begin
        if (pmem_resp) begin
          d_resp     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Address and write data stay at their last latched value after completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      last_d       <= 1'b0;
    end else if (grant_i) begin
      pmem_address <= i_address;
      pmem_wdata   <= i_wdata;
      pmem_write   <= i_write;
      pmem_read    <= i_read & ~i_write;
      last_d       <= 1'b0;
    end else if (grant_d) begin
      pmem_address <= d_address;
      pmem_wdata   <= d_wdata;
      pmem_write   <= d_write;
      pmem_read    <= d_read & ~d_write;
      last_d       <= 1'b1;
    end else if (state != IDLE && pmem_resp) begin
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
    end
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter against a transaction-level owner model,
// preceded by directed scenarios with hand-computed expectations.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rq_rd [2];
  logic         rq_wr [2];
  logic [31:0]  rq_a  [2];
  logic [255:0] rq_w  [2];
  logic [255:0] i_rdata, d_rdata, pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         i_resp, d_resp, pmem_read, pmem_write;
  logic         pmem_resp = 1'b0;
  logic [31:0]  pmem_address;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: who owns memory (-1 none, 0 icache, 1 dcache), who won last, latched command.
  int           owner = -1;
  int           last  = 0;
  logic [31:0]  m_addr = '0;
  logic [255:0] m_wdata = '0;
  logic         m_rd = 1'b0, m_wr = 1'b0;
  logic         e_resp [2];

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_address(rq_a[0]), .i_read(rq_rd[0]), .i_write(rq_wr[0]), .i_wdata(rq_w[0]),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(rq_a[1]), .d_read(rq_rd[1]), .d_write(rq_wr[1]), .d_wdata(rq_w[1]),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    owner = -1; last = 0; m_addr = '0; m_wdata = '0; m_rd = 1'b0; m_wr = 1'b0;
  endtask

  // Advances the model across one rising edge using the inputs present at that edge.
  task automatic model_update();
    int win;
    if (!rst) begin
      model_reset();
    end else if (owner < 0) begin
      win = -1;
      if ((rq_rd[0] | rq_wr[0]) && (rq_rd[1] | rq_wr[1])) win = 1 - last;
      else if (rq_rd[0] | rq_wr[0]) win = 0;
      else if (rq_rd[1] | rq_wr[1]) win = 1;
      if (win >= 0) begin
        owner   = win;
        last    = win;
        m_addr  = rq_a[win];
        m_wdata = rq_w[win];
        m_wr    = rq_wr[win];
        m_rd    = rq_rd[win] & ~rq_wr[win];
      end
    end else if (pmem_resp) begin
      owner = -1; m_rd = 1'b0; m_wr = 1'b0;
    end
  endtask

  task automatic settle();
    #1;
    if (!rst) model_reset();
    e_resp[0] = (owner == 0) && pmem_resp;
    e_resp[1] = (owner == 1) && pmem_resp;
    check("pmem_read", 256'(pmem_read), 256'(m_rd));
    check("pmem_write", 256'(pmem_write), 256'(m_wr));
    check("pmem_address", 256'(pmem_address), 256'(m_addr));
    check("pmem_wdata", pmem_wdata, m_wdata);
    check("i_resp", 256'(i_resp), 256'(e_resp[0]));
    check("d_resp", 256'(d_resp), 256'(e_resp[1]));
    if (e_resp[0]) check("i_rdata", i_rdata, pmem_rdata);
    if (e_resp[1]) check("d_rdata", d_rdata, pmem_rdata);
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      rq_rd[k] = 1'b0; rq_wr[k] = 1'b0; rq_a[k] = '0; rq_w[k] = '0;
    end
    pmem_resp = 1'b0;
  endtask

  initial begin
    clear_inputs();
    e_resp[0] = 1'b0; e_resp[1] = 1'b0;
    @(negedge clk);
    settle();
    check("reset_pmem_read", 256'(pmem_read), 256'(0));
    adv(); settle(); adv();
    rst = 1'b1;

    // single read
    rq_rd[0] = 1'b1; rq_a[0] = 32'h0000_1A40;
    settle(); adv();
    settle();
    check("single_read_cmd", 256'(pmem_read), 256'(1));
    check("single_read_addr", 256'(pmem_address), 256'(32'h0000_1A40));
    adv();
    for (int c = 2; c < 5; c++) begin settle(); adv(); end
    pmem_resp = 1'b1; pmem_rdata = {8{32'hDEADBEEF}};
    settle();
    check("single_read_resp", 256'(i_resp), 256'(1));
    check("single_read_data", i_rdata, {8{32'hDEADBEEF}});
    adv();
    pmem_resp = 1'b0; rq_rd[0] = 1'b0;
    settle();
    check("single_read_done", 256'(pmem_read), 256'(0));
    adv();

    // tie then round-robin
    rq_rd[0] = 1'b1; rq_a[0] = 32'h100; rq_rd[1] = 1'b1; rq_a[1] = 32'h200;
    settle(); adv();
    settle();
    check("tie_d_first", 256'(pmem_address), 256'(32'h200));
    adv(); settle(); adv();
    pmem_resp = 1'b1;
    settle();
    check("tie_d_resp", 256'(d_resp), 256'(1));
    adv();
    pmem_resp = 1'b0; rq_rd[1] = 1'b0;
    settle();
    check("rr_gap", 256'(pmem_read), 256'(0));
    adv();
    rq_rd[1] = 1'b1;
    settle();
    check("rr_i_cmd", 256'(pmem_read), 256'(1));
    check("rr_i_addr", 256'(pmem_address), 256'(32'h100));
    adv();
    pmem_resp = 1'b1;
    settle(); adv();
    pmem_resp = 1'b0; rq_rd[0] = 1'b0;
    settle();
    check("rr_gap2", 256'(pmem_read), 256'(0));
    adv();
    settle();
    check("rr_d_again", 256'(pmem_address), 256'(32'h200));
    adv();
    pmem_resp = 1'b1;
    settle(); adv();
    pmem_resp = 1'b0; rq_rd[1] = 1'b0;
    settle(); adv();

    // latching of write command
    rq_wr[1] = 1'b1; rq_w[1] = {8{32'hAAAA5555}}; rq_a[1] = 32'h300;
    settle(); adv();
    rq_w[1] = {8{32'h1234_5678}}; rq_a[1] = 32'h340;
    settle();
    check("latch_wdata", pmem_wdata, {8{32'hAAAA5555}});
    check("latch_addr", 256'(pmem_address), 256'(32'h300));
    check("latch_write", 256'(pmem_write), 256'(1));
    adv(); settle(); adv();
    pmem_resp = 1'b1;
    settle(); adv();
    pmem_resp = 1'b0; rq_wr[1] = 1'b0;
    settle(); adv();

    // drop mid-transaction
    rq_rd[0] = 1'b1; rq_a[0] = 32'h400;
    settle(); adv();
    settle(); adv();
    rq_rd[0] = 1'b0;
    settle();
    check("drop_hold", 256'(pmem_read), 256'(1));
    adv(); settle(); adv();
    pmem_resp = 1'b1;
    settle();
    check("drop_resp", 256'(i_resp), 256'(1));
    adv();
    pmem_resp = 1'b0;
    settle();
    check("drop_one_pulse", 256'(i_resp), 256'(0));
    adv();

    // read+write together, then stray response in IDLE
    rq_rd[1] = 1'b1; rq_wr[1] = 1'b1; rq_a[1] = 32'h500;
    settle(); adv();
    settle();
    check("rw_write", 256'(pmem_write), 256'(1));
    check("rw_read", 256'(pmem_read), 256'(0));
    adv();
    pmem_resp = 1'b1;
    settle(); adv();
    pmem_resp = 1'b0; rq_rd[1] = 1'b0; rq_wr[1] = 1'b0;
    settle(); adv();
    pmem_resp = 1'b1;
    settle();
    check("stray_i_resp", 256'(i_resp), 256'(0));
    check("stray_d_resp", 256'(d_resp), 256'(0));
    adv();
    pmem_resp = 1'b0;
    settle();
    check("stray_idle_cmd", 256'({pmem_read, pmem_write}), 256'(0));
    adv();

    // reset in the middle of a dcache read
    rq_rd[1] = 1'b1; rq_a[1] = 32'h600;
    settle(); adv();
    settle();
    check("pre_reset_cmd", 256'(pmem_read), 256'(1));
    rst = 1'b0;
    settle();
    check("reset_async_cmd", 256'(pmem_read), 256'(0));
    check("reset_async_addr", 256'(pmem_address), 256'(0));
    adv();
    rq_rd[0] = 1'b1; rq_a[0] = 32'h700;
    rst = 1'b1;
    settle(); adv();
    settle();
    check("reset_tie_d", 256'(pmem_address), 256'(32'h600));
    adv();
    pmem_resp = 1'b1;
    settle(); adv();
    clear_inputs();
    settle(); adv();

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (rq_rd[k] | rq_wr[k]) begin
          if (e_resp[k]) begin
            if ($urandom_range(0, 7) != 0) begin rq_rd[k] = 1'b0; rq_wr[k] = 1'b0; end
          end else if ($urandom_range(0, 15) == 0) begin
            rq_rd[k] = 1'b0; rq_wr[k] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            rq_a[k] = $urandom;
            for (int j = 0; j < 8; j++) rq_w[k][j*32 +: 32] = $urandom;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          rq_a[k] = $urandom & ~32'h1f;
          for (int j = 0; j < 8; j++) rq_w[k][j*32 +: 32] = $urandom;
          rq_rd[k] = 1'($urandom_range(0, 1));
          rq_wr[k] = rq_rd[k] ? ($urandom_range(0, 3) == 0) : 1'b1;
        end
      end
      if (m_rd | m_wr) pmem_resp = ($urandom_range(0, 2) == 0);
      else             pmem_resp = ($urandom_range(0, 15) == 0);
      for (int j = 0; j < 8; j++) pmem_rdata[j*32 +: 32] = $urandom;
      settle();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter that shares the single physical-memory line port between the instruction cache and the data cache. It sits between the two `cache` instances' `pmem_*` sides and main memory. Each cache sees a private, non-aborting line port. The arbiter grants one whole 256-bit line transaction at a time, using round-robin on ties. It latches the winner's command, holds it stable toward memory until `pmem_resp`, and routes the response back to the winner.

## Interface
- `s_addr`, 32: address width.
- `s_line`, 256: line width in bits.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_address` in s_addr: icache line address.
- `i_read` in 1: icache line read request; held until `i_resp`.
- `i_write` in 1: icache line write request; held until `i_resp`.
- `i_wdata` in s_line: icache write line.
- `i_rdata` out s_line: read line to icache.
- `i_resp` out 1: one-cycle completion pulse to icache.
- `d_address`, `d_read`, `d_write`, `d_wdata`, `d_rdata`, `d_resp`: same as the `i_*` ports, for the dcache.
- `pmem_address` out s_addr: memory line address.
- `pmem_read` out 1: memory read command.
- `pmem_write` out 1: memory write command.
- `pmem_wdata` out s_line: memory write line.
- `pmem_rdata` in s_line: memory read line.
- `pmem_resp` in 1: memory completion; valid for exactly one cycle.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - BUSY_I: icache transaction in flight.
  - BUSY_D: dcache transaction in flight.
- A requester is pending when `x_read | x_write`.
- IDLE, one requester pending: go to BUSY for that requester.
- IDLE, both pending: grant the requester that is not `last_grant`.
- IDLE, none pending: stay in IDLE.
- On every grant, register in the same edge:
  - `pmem_address` from the winner's address;
  - `pmem_wdata` from the winner's write data;
  - command: `pmem_write` from the winner's `write`, and `pmem_read` from `read & ~write`, so write wins if both are high;
  - `last_grant` set to the winner.
- BUSY_x:
  - `pmem_*` outputs come only from the latched copy; requester input changes are ignored until completion.
  - On a cycle with `pmem_resp = 1`, drive `x_resp = 1` combinationally in that same cycle.
  - On that edge, clear the latched command (`pmem_read`/`pmem_write` go to 0) and return to IDLE.
  - No direct handoff: the other requester is granted from IDLE on the following edge.
  - `pmem_address`/`pmem_wdata` keep their last latched values after completion.
- `i_rdata = d_rdata = pmem_rdata` unconditionally; valid only while the matching `x_resp` is high.
- `x_resp` is never asserted outside BUSY_x. `pmem_resp` in IDLE is ignored (protocol error; no state change).
- A requester dropping its request mid-transaction does not abort it. The memory operation completes and `x_resp` still pulses.
- `i_resp` and `d_resp` are never high in the same cycle.

## Timing
- Reset (`rst = 0`, async), all registered values cleared:
  - state = IDLE;
  - `pmem_read = pmem_write = 0`, `pmem_address = 0`, `pmem_wdata = 0`;
  - `i_resp = d_resp = 0`;
  - `last_grant = I`, so the first tie goes to D.
- Reset assertion mid-transaction drops the command immediately. No `x_resp` is generated for the aborted transaction.
- Grant latency: request pending in IDLE cycle N → `pmem_read`/`pmem_write` high from cycle N+1.
- Completion: `pmem_resp` in cycle M → `x_resp` and `x_rdata` valid in cycle M. Memory command is low in cycle M+1 (IDLE).
- Back-to-back: the next grant edge is the end of M+1, so the next memory command starts at M+2. There is a minimum of one idle memory cycle between transactions.
- A requester still holding its request in cycle M+1 (it has not yet deasserted) is treated as a new request. The requester must deassert in M+1 to avoid a re-issue; the caches already do this.
- Worst-case wait for a pending requester: one full foreign transaction plus 2 cycles.

## Test plan
- Reset behaviour: `rst = 0` while `pmem_read` is high in BUSY_D → all outputs 0 on the same cycle. After release, state is IDLE and the first tie is granted to D.
- Single read: `i_read = 1`, `i_address = 0x0000_1A40` at cycle 0 → `pmem_read = 1`, `pmem_address = 0x0000_1A40` at cycle 1. With `pmem_resp` at cycle 5 and `pmem_rdata = {8{32'hDEADBEEF}}`: `i_resp = 1` with that data at cycle 5, and `pmem_read = 0` at cycle 6.
- Tie and round-robin: both read continuously at cycle 0 → D granted first. Then I, with `pmem_read` low for exactly one cycle between the transactions. Then D again.
- Latching: `d_write = 1`, `d_wdata = A` granted; the dcache then changes `d_wdata` to B and `d_address` before `pmem_resp` → `pmem_wdata` stays A, `pmem_address` stays at the original value.
- Drop mid-transaction: `i_read` deasserted two cycles after grant → `pmem_read` held until `pmem_resp`, and `i_resp` still pulses once.
- Read and write both asserted on the dcache → `pmem_write = 1`, `pmem_read = 0`. A stray `pmem_resp` in IDLE causes no `x_resp` and no state change.
